// File: rtl/simon_data_in_pkg.sv
// Shared SIMON inbound-packet definitions: word width default, packet length,
// receiver FSM states and one reference packet with its unpacked fields.
package simon_data_in_pkg;

  localparam int N_DEFAULT = 16;

  // Packet length in bytes: info + count + two N-bit words.
  function automatic int pkt_bytes(input int n);
    return 2 + n / 4;
  endfunction

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    PRESENT = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Reference packet for N=16, listed byte 5 down to byte 0.
  localparam logic [47:0] TEST_PKT   = {8'h34, 8'h12, 8'h78, 8'h56, 8'h00, 8'hA5};
  localparam logic [7:0]  TEST_INFO  = 8'hA5;
  localparam logic [7:0]  TEST_COUNT = 8'h00;
  localparam logic [15:0] TEST_WORD0 = 16'h7856;
  localparam logic [15:0] TEST_WORD1 = 16'h3412;

endpackage

// File: rtl/simon_pkt_unpack.sv
// Combinational slicer from a packed host packet to its info, count and
// two little-endian N-bit data words.
module simon_pkt_unpack #(
  parameter int N = 16,
  localparam int PKT_BYTES = 2 + N / 4
) (
  input  logic [PKT_BYTES*8-1:0] in,
  output logic [7:0]             info,
  output logic [7:0]             count,
  output logic [N-1:0]           word0,
  output logic [N-1:0]           word1
);

  assign info  = in[7:0];
  assign count = in[15:8];
  // Payload starts at byte 2; word 0 takes the low N payload bits.
  assign word0 = in[16 +: N];
  assign word1 = in[16+N +: N];

endmodule

// File: rtl/simon_data_in.sv
// Host-side SIMON packet receiver: 4-phase packet capture, 4-phase handoff of
// the unpacked fields to the core, and a sticky sequence-gap flag.
module simon_data_in
  import simon_data_in_pkg::*;
#(
  parameter int N = N_DEFAULT,
  localparam int PKT_BYTES = pkt_bytes(N)
) (
  input  logic                   clk,
  input  logic                   nR,
  input  logic [PKT_BYTES*8-1:0] in,
  input  logic                   in_donePKT,
  output logic                   in_readPKT,
  output logic [7:0]             infoIN,
  output logic [7:0]             countIN,
  output logic [1:0][N-1:0]      inDATA,
  output logic                   doneDATA,
  input  logic                   readDATA,
  output logic                   seq_err,
  output state_t                 dbgState
);

  // Both handshakes are level-based 4-phase: a request stays high until the
  // matching acknowledge is seen, then drops; the acknowledge drops after that.

  state_t         state;
  logic [7:0]     expCnt;
  logic [7:0]     pktInfo;
  logic [7:0]     pktCount;
  logic [N-1:0]   pktWord0;
  logic [N-1:0]   pktWord1;

  simon_pkt_unpack #(.N(N)) u_unpack (
    .in    (in),
    .info  (pktInfo),
    .count (pktCount),
    .word0 (pktWord0),
    .word1 (pktWord1)
  );

  assign dbgState = state;

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      state      <= IDLE;
      in_readPKT <= 1'b0;
      doneDATA   <= 1'b0;
      seq_err    <= 1'b0;
      infoIN     <= '0;
      countIN    <= '0;
      inDATA     <= '0;
      expCnt     <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (in_donePKT) begin
            infoIN     <= pktInfo;
            countIN    <= pktCount;
            inDATA[0]  <= pktWord0;
            inDATA[1]  <= pktWord1;
            if (pktCount != expCnt) seq_err <= 1'b1;
            // Always follow the received count so a single gap flags once.
            expCnt     <= pktCount + 8'd1;
            in_readPKT <= 1'b1;
            state      <= ACK;
          end
        end
        ACK: begin
          if (!in_donePKT) begin
            in_readPKT <= 1'b0;
            doneDATA   <= 1'b1;
            state      <= PRESENT;
          end
        end
        PRESENT: begin
          if (readDATA) begin
            doneDATA <= 1'b0;
            state    <= RELEASE;
          end
        end
        RELEASE: begin
          if (!readDATA) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_data_in.sv
// Directed bench for simon_data_in (N=16): host driver, core responder,
// and a scoreboard monitor that checks each presented packet in order.
module tb_simon_data_in;
  import simon_data_in_pkg::*;

  localparam int N = 16;
  localparam int W = 16 + 2 * N;

  logic              clk = 1'b0;
  logic              nR;
  logic [W-1:0]      in;
  logic              in_donePKT;
  logic              in_readPKT;
  logic [7:0]        infoIN;
  logic [7:0]        countIN;
  logic [1:0][N-1:0] inDATA;
  logic              doneDATA;
  logic              readDATA;
  logic              seq_err;
  state_t            dbgState;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic coreEn = 1'b0;
  logic prevDone = 1'b0;
  logic [W-1:0] exp_q[$];

  simon_data_in #(.N(N)) dut (
    .clk        (clk),
    .nR         (nR),
    .in         (in),
    .in_donePKT (in_donePKT),
    .in_readPKT (in_readPKT),
    .infoIN     (infoIN),
    .countIN    (countIN),
    .inDATA     (inDATA),
    .doneDATA   (doneDATA),
    .readDATA   (readDATA),
    .seq_err    (seq_err),
    .dbgState   (dbgState)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic do_reset();
    nR = 1'b0;
    repeat (3) @(negedge clk);
    nR = 1'b1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_readPKT"}, 64'(in_readPKT), 64'd0);
    chk({tag, "_doneDATA"}, 64'(doneDATA), 64'd0);
    chk({tag, "_seq_err"}, 64'(seq_err), 64'd0);
    chk({tag, "_fields"}, {16'h0, infoIN, countIN, inDATA[1], inDATA[0]}, 64'd0);
    chk({tag, "_state"}, 64'(dbgState), 64'(IDLE));
  endtask

  // ---------------- host driver ----------------
  function automatic logic [W-1:0] mk_in(input logic [7:0] info, input logic [7:0] cnt,
                                         input logic [2*N-1:0] payload);
    return {payload, cnt, info};
  endfunction

  function automatic logic [W-1:0] mk_exp(input logic [7:0] info, input logic [7:0] cnt,
                                          input logic [2*N-1:0] payload);
    return {info, cnt, payload[2*N-1:N], payload[N-1:0]};
  endfunction

  task automatic host_raise(input logic [W-1:0] pkt, input logic [W-1:0] expv);
    int n = 0;
    while (in_readPKT && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_readPKT) fail_now("ack_release");
    in = pkt;
    in_donePKT = 1'b1;
    exp_q.push_back(expv);
  endtask

  task automatic host_wait_ack(output int lat);
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (in_readPKT) break;
    end
    if (!in_readPKT) fail_now("ack_wait");
    in_donePKT = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 100 && !(dbgState == IDLE && !doneDATA && !readDATA && !in_readPKT)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("idle_wait");
  endtask

  task automatic send_full(input logic [7:0] info, input logic [7:0] cnt,
                           input logic [2*N-1:0] payload);
    int lat;
    host_raise(mk_in(info, cnt, payload), mk_exp(info, cnt, payload));
    host_wait_ack(lat);
    wait_idle();
  endtask

  // ---------------- core responder ----------------
  initial begin
    readDATA = 1'b0;
    forever begin
      @(negedge clk);
      if (!coreEn) readDATA = 1'b0;
      else if (doneDATA && !readDATA) readDATA = 1'b1;
      else if (readDATA && !doneDATA) readDATA = 1'b0;
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (doneDATA && !prevDone) begin
        if (exp_q.size() == 0) fail_now("unexpected_present");
        else begin
          e = exp_q.pop_front();
          chk("present_fields", {16'h0, infoIN, countIN, inDATA[1], inDATA[0]}, {16'h0, e});
        end
      end
      prevDone = doneDATA;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int lastCap;
    nR = 1'b1;
    in = '0;
    in_donePKT = 1'b0;
    @(negedge clk);

    // Reset values, then quiet IDLE after release.
    nR = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_zero("in_reset");
    nR = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle_zero("after_reset");

    // Single reference packet with the core stalled.
    coreEn = 1'b0;
    host_raise(TEST_PKT, {TEST_INFO, TEST_COUNT, TEST_WORD1, TEST_WORD0});
    host_wait_ack(lat);
    chk("ack_latency", 64'(lat), 64'd1);
    @(negedge clk);
    chk("single_doneDATA", 64'(doneDATA), 64'd1);
    chk("single_readPKT", 64'(in_readPKT), 64'd0);
    chk("single_info", 64'(infoIN), 64'hA5);
    chk("single_count", 64'(countIN), 64'h00);
    chk("single_word0", 64'(inDATA[0]), 64'h7856);
    chk("single_word1", 64'(inDATA[1]), 64'h3412);
    chk("single_seq_err", 64'(seq_err), 64'd0);

    // Back-pressure: next packet (count 01) waits while the core holds off.
    host_raise(mk_in(8'h3C, 8'h01, 32'hCAFE_F00D), mk_exp(8'h3C, 8'h01, 32'hCAFE_F00D));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_no_ack", 64'(in_readPKT), 64'd0);
      chk("bp_hold_fields", {32'h0, countIN, infoIN, inDATA[0]}, {32'h0, 8'h00, 8'hA5, 16'h7856});
    end
    coreEn = 1'b1;
    host_wait_ack(lat);
    wait_idle();
    chk("bp_seq_err", 64'(seq_err), 64'd0);

    // Sequence gap: 00,01,03,04.
    do_reset();
    send_full(8'h11, 8'h00, 32'h0000_0001); chk("seq_00", 64'(seq_err), 64'd0);
    send_full(8'h12, 8'h01, 32'h0000_0002); chk("seq_01", 64'(seq_err), 64'd0);
    send_full(8'h13, 8'h03, 32'h0000_0003); chk("seq_03", 64'(seq_err), 64'd1);
    send_full(8'h14, 8'h04, 32'h0000_0004); chk("seq_04", 64'(seq_err), 64'd1);

    // First packet FE flags; FF and 00 follow on without clearing.
    do_reset();
    chk("seq_cleared", 64'(seq_err), 64'd0);
    send_full(8'h21, 8'hFE, 32'h1111_2222); chk("seq_FE", 64'(seq_err), 64'd1);
    send_full(8'h22, 8'hFF, 32'h3333_4444); chk("seq_FF", 64'(seq_err), 64'd1);
    send_full(8'h23, 8'h00, 32'h5555_6666); chk("seq_wrap00", 64'(seq_err), 64'd1);

    // Reset while presenting: outputs clear before the next edge.
    do_reset();
    coreEn = 1'b0;
    host_raise(mk_in(8'h77, 8'h00, 32'hDEAD_BEEF), mk_exp(8'h77, 8'h00, 32'hDEAD_BEEF));
    host_wait_ack(lat);
    @(negedge clk);
    chk("mid_doneDATA_pre", 64'(doneDATA), 64'd1);
    #2 nR = 1'b0;
    #1;
    chk("mid_doneDATA", 64'(doneDATA), 64'd0);
    chk("mid_readPKT", 64'(in_readPKT), 64'd0);
    chk("mid_fields", {16'h0, infoIN, countIN, inDATA[1], inDATA[0]}, 64'd0);
    repeat (3) @(negedge clk);
    nR = 1'b1;
    coreEn = 1'b1;
    send_full(8'h78, 8'h00, 32'h0BAD_F00D);
    chk("mid_after_seq_err", 64'(seq_err), 64'd0);

    // Minimum-latency loop through the full count range and the 8-bit wrap.
    do_reset();
    lastCap = 0;
    for (int i = 0; i < 258; i++) begin
      logic [7:0] c;
      c = 8'(i);
      host_raise(mk_in(~c, c, {c, 8'h5A, ~c, 8'(i * 3)}), mk_exp(~c, c, {c, 8'h5A, ~c, 8'(i * 3)}));
      host_wait_ack(lat);
      if (i > 0) chk("loop_period", 64'(cyc - lastCap), 64'd4);
      lastCap = cyc;
    end
    wait_idle();
    chk("loop_seq_err", 64'(seq_err), 64'd0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
